// File: rtl/minibus_pkg.sv
// Shared minibus types: request/response packs, decoder state and region descriptors.
package minibus_pkg;

  localparam int MINIBUS_MAX_SLAVES = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } minibus_req_pack;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } minibus_res_pack;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} minibus_dec_state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } minibus_region_t;

  // Index width that stays legal for a single-slave build.
  function automatic int minibus_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/minibus_addr_match.sv
// Combinational address-to-region matcher; the lowest matching index wins.
module minibus_addr_match
  import minibus_pkg::*;
#(
  parameter  int NUM_SLAVES = 4,
  localparam int IDX_W      = minibus_idx_w(NUM_SLAVES)
) (
  input  logic [31:0]     addr,
  input  minibus_region_t regions [NUM_SLAVES],
  output logic            hit,
  output logic [IDX_W-1:0] idx
);

  logic [NUM_SLAVES-1:0] match;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
    assign match[gi] = ((addr ^ regions[gi].base) & regions[gi].mask) == 32'h0;
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/minibus_decoder.sv
// Single-master minibus decoder: selects one slave per request, relays its response,
// and answers unmapped, illegal (ren=wen=1) and timed-out accesses with an error.
module minibus_decoder
  import minibus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS     = {32'h2000_0000, 32'h1000_0000,
                                                        32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] ADDR_MASKS     = {32'hFF00_0000, 32'hFF00_0000,
                                                        32'hFFFF_F000, 32'hFFFF_F000},
  parameter int                       TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  minibus_req_pack       mst_req,
  output minibus_res_pack       mst_res,
  output logic [NUM_SLAVES-1:0] slv_sel,
  output minibus_req_pack       slv_req,
  input  minibus_res_pack       slv_res [NUM_SLAVES],
  output logic                  busy,
  output logic                  timeout_evt
);

  localparam int IDX_W = minibus_idx_w(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  minibus_region_t regions [NUM_SLAVES];

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_region
    assign regions[gi].base = BASE_ADDRS[32*gi +: 32];
    assign regions[gi].mask = ADDR_MASKS[32*gi +: 32];
  end

  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  minibus_addr_match #(.NUM_SLAVES(NUM_SLAVES)) u_match (
    .addr    (mst_req.addr),
    .regions (regions),
    .hit     (hit),
    .idx     (hit_idx)
  );

  minibus_dec_state_t    state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  minibus_req_pack       req_q, req_d;
  minibus_res_pack       res_q, res_d;
  logic                  tmo_q, tmo_d;
  minibus_res_pack       cur_res;

  assign cur_res = slv_res[idx_q];

  // mst_res and timeout_evt default to zero so they only pulse in the RESP cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    req_d   = req_q;
    res_d   = '0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mst_req.ren || mst_req.wen) begin
          if (hit && (mst_req.ren ^ mst_req.wen)) begin
            state_d        = ACCESS;
            req_d          = mst_req;
            idx_d          = hit_idx;
            cnt_d          = '0;
            sel_d          = '0;
            sel_d[hit_idx] = 1'b1;
          end else begin
            state_d     = RESP;
            res_d.ready = 1'b1;
            res_d.error = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cur_res.ready) begin
          state_d     = RESP;
          sel_d       = '0;
          req_d       = '0;
          res_d.ready = 1'b1;
          res_d.error = cur_res.error;
          res_d.rdata = req_q.wen ? 32'h0 : cur_res.rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          sel_d       = '0;
          req_d       = '0;
          res_d.ready = 1'b1;
          res_d.error = 1'b1;
          tmo_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      req_q   <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mst_res     = res_q;
  assign slv_sel     = sel_q;
  assign slv_req     = req_q;
  assign timeout_evt = tmo_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_minibus_decoder.sv
// Randomized bench for minibus_decoder with an address-map reference model and
// per-transaction slave latency; also covers timeout and mid-access reset.
module tb_minibus_decoder;
  import minibus_pkg::*;

  localparam int NS  = 4;
  localparam int TMO = 256;
  localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h0000_1000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [31:0] MASK [NS] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFF00_0000, 32'hFF00_0000};

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  minibus_req_pack mst_req;
  minibus_res_pack mst_res;
  logic [NS-1:0]   slv_sel;
  minibus_req_pack slv_req;
  minibus_res_pack slv_res [NS];
  logic            busy;
  logic            timeout_evt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  minibus_decoder dut (
    .clk         (clk),
    .nrst        (nrst),
    .mst_req     (mst_req),
    .mst_res     (mst_res),
    .slv_sel     (slv_sel),
    .slv_req     (slv_req),
    .slv_res     (slv_res),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int ref_decode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++)
      if ((addr & MASK[i]) == (BASE[i] & MASK[i])) return i;
    return -1;
  endfunction

  task automatic junk(input bit all_ready);
    for (int i = 0; i < NS; i++) begin
      slv_res[i].ready = all_ready | 1'($urandom_range(0, 1));
      slv_res[i].error = 1'($urandom_range(0, 1));
      slv_res[i].rdata = $urandom;
    end
  endtask

  // One master transaction; the target slave answers after wait_n extra ACCESS cycles.
  task automatic run_txn(input logic [31:0] addr, input logic ren, input logic wen,
                         input int wait_n, input logic s_err, input logic [31:0] s_rdata,
                         input bit noisy);
    minibus_req_pack req;
    int              tgt, exp_lat, exp_sel_n, n, sel_n;
    bit              done;
    logic            exp_err, exp_tmo;
    logic [31:0]     exp_rd;
    req.addr  = addr;
    req.ren   = ren;
    req.wen   = wen;
    req.wdata = $urandom;
    req.wstrb = 4'($urandom_range(1, 15));
    tgt = ref_decode(addr);
    if (tgt < 0 || ren == wen) begin
      tgt = -1; exp_lat = 1; exp_err = 1'b1; exp_rd = 32'h0; exp_tmo = 1'b0; exp_sel_n = 0;
    end else if (wait_n >= TMO) begin
      exp_lat = TMO + 1; exp_err = 1'b1; exp_rd = 32'h0; exp_tmo = 1'b1; exp_sel_n = TMO;
    end else begin
      exp_lat = wait_n + 2; exp_err = s_err; exp_rd = wen ? 32'h0 : s_rdata;
      exp_tmo = 1'b0; exp_sel_n = wait_n + 1;
    end
    junk(noisy);
    mst_req = req;
    @(posedge clk);
    n = 0; sel_n = 0; done = 0;
    while (!done && n < TMO + 20) begin
      @(negedge clk);
      n++;
      junk(noisy);
      if (slv_sel != '0) begin
        sel_n++;
        chk("sel", slv_sel, (tgt >= 0) ? (NS'(1) << tgt) : NS'(0));
        chk("slv_req", slv_req, req);
      end
      if (mst_res.ready) begin
        done = 1;
        chk("latency", n, exp_lat);
        chk("error", mst_res.error, exp_err);
        chk("rdata", mst_res.rdata, exp_rd);
        chk("timeout_evt", timeout_evt, exp_tmo);
        chk("sel_cycles", sel_n, exp_sel_n);
        chk("slv_req_clr", slv_req, 0);
        chk("busy_resp", busy, 1);
      end else if (tgt >= 0) begin
        slv_res[tgt].ready = (sel_n == wait_n + 1);
        slv_res[tgt].error = s_err;
        slv_res[tgt].rdata = s_rdata;
      end
    end
    if (!done) chk("resp_wait", 0, 1);
    $display("txn addr=%08h ren=%0b wen=%0b wait=%0d lat=%0d sel_cycles=%0d", addr, ren, wen, wait_n, n, sel_n);
    mst_req = '0;
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("ready_pulse", mst_res.ready, 0);
  endtask

  initial begin
    logic [31:0] a;
    int          r, k;
    mst_req = '0;
    junk(0);
    repeat (2) @(negedge clk);
    chk("rst_sel", slv_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", mst_res, 0);
    chk("rst_req", slv_req, 0);
    chk("rst_tmo", timeout_evt, 0);
    nrst = 1'b1;
    @(negedge clk);

    run_txn(32'h0000_1004, 1'b1, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, 0);
    run_txn(32'h2000_0010, 1'b0, 1'b1, 3, 1'b0, 32'hCAFE_F00D, 0);
    run_txn(32'h3000_0000, 1'b1, 1'b0, 0, 1'b0, 32'h1111_2222, 0);
    run_txn(32'h0000_0000, 1'b1, 1'b1, 0, 1'b0, 32'h3333_4444, 0);
    run_txn(32'h0000_0000, 1'b1, 1'b0, 300, 1'b0, 32'h5555_6666, 0);

    // Reset in the middle of an access to slave2.
    mst_req      = '0;
    mst_req.addr = 32'h1000_0040;
    mst_req.ren  = 1'b1;
    for (int i = 0; i < NS; i++) slv_res[i] = '0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("pre_rst_sel", slv_sel, 4'b0100);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_sel", slv_sel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res", mst_res, 0);
    chk("mid_rst_req", slv_req, 0);
    mst_req = '0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", mst_res, 0);
    end
    run_txn(32'h0000_0100, 1'b1, 1'b0, 1, 1'b0, 32'h0BAD_CAFE, 0);

    // Back-to-back with every unselected slave holding ready high.
    run_txn(32'h0000_0020, 1'b1, 1'b0, 0, 1'b0, 32'hA5A5_0001, 1);
    run_txn(32'h0000_1020, 1'b1, 1'b0, 0, 1'b0, 32'hA5A5_0002, 1);
    run_txn(32'h1000_0000, 1'b1, 1'b0, 4, 1'b1, 32'hA5A5_0003, 1);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 5);
      if (r < NS)      a = BASE[r] | (~MASK[r] & $urandom);
      else if (r == 4) a = 32'h3000_0000 | (32'h00FF_FFFF & $urandom);
      else             a = 32'h0000_2000 | (32'h0000_0FFF & $urandom);
      k = $urandom_range(0, 7);
      run_txn(a, (k < 4) ? 1'b1 : 1'b0, (k == 0 || k >= 4) ? 1'b1 : 1'b0,
              $urandom_range(0, 6), 1'($urandom_range(0, 3) == 0), $urandom,
              1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
